player_hit_manager: RTL and testbench
=====================================

Name: player_hit_manager

Overview:
Consumes the once-per-frame hit pulse from the player/poop collision stage and keeps the player's life count. After each hit it enforces a frame-counted invulnerability window with a blink, and flags game over. Sits between the collision detector and the player drawing, score and HUD logic.

Parameters:
INIT_LIVES, 3, lives loaded at reset and on restart (1..2^LIVES_W-1)
LIVES_W, 3, width of lives output
INVULN_FRAMES, 90, frames of invulnerability after a non-fatal hit (>=1)
BLINK_PERIOD, 8, frames per blink half-period during invulnerability (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
startOfFrame  in  1  one-cycle pulse at frame start
hitPulse  in  1  collision hit level; rises at most once per frame, held until next startOfFrame
restart  in  1  synchronous one-cycle request to start a new game
lives  out  LIVES_W  remaining lives
invulnerable  out  1  high while in INVULN
playerVisible  out  1  gate for the player drawing request
gameOver  out  1  high in GAME_OVER
lifeLostPulse  out  1  one-cycle pulse per accepted hit

Behaviour:
- Reset values (async, reset=1):
  - state=ALIVE, lives=INIT_LIVES
  - invulnerable=0, playerVisible=1, gameOver=0, lifeLostPulse=0
  - hitPrev=0, invCnt=0, blinkCnt=0, blinkPhase=0
- Asserting reset mid-operation returns all of the above immediately, in any state.
- Edge detect: hitEdge = hitPulse & ~hitPrev. hitPrev <= hitPulse every cycle in every state, so a pulse held across a state change never retriggers.
- FSM states: ALIVE, INVULN, GAME_OVER. All outputs are registered.
- ALIVE, on hitEdge:
  - lives <= lives-1 and lifeLostPulse=1 for exactly the next cycle.
  - If lives==1: lives <= 0, go to GAME_OVER.
  - Otherwise go to INVULN with invCnt <= INVULN_FRAMES, blinkCnt <= 0, blinkPhase <= 0 (hidden).
- INVULN:
  - hitEdge is ignored: lives unchanged, no pulse.
  - On each startOfFrame: invCnt decrements and blinkCnt increments.
  - When blinkCnt==BLINK_PERIOD-1 it wraps to 0 and blinkPhase toggles.
  - When startOfFrame arrives with invCnt==1, go to ALIVE.
  - Net result: exactly INVULN_FRAMES frame starts are spent in INVULN.
- A startOfFrame in the same cycle as the ALIVE->INVULN transition does not decrement; the counter is loaded.
- GAME_OVER: all hits are ignored; lives=0, gameOver=1. Only restart or reset leaves this state.
- Outputs by state:
  - invulnerable = (state==INVULN)
  - gameOver = (state==GAME_OVER)
  - playerVisible = 1 in ALIVE and GAME_OVER, blinkPhase in INVULN
- restart, from any state: lives <= INIT_LIVES, state <= ALIVE, counters and blinkPhase cleared, lifeLostPulse <= 0.
- restart has priority over a hitEdge in the same cycle; that hit is discarded, but hitPrev still updates.
- Widths: invCnt is $clog2(INVULN_FRAMES+1) bits; blinkCnt is $clog2(BLINK_PERIOD+1) bits. lives never underflows below 0.
- Latency: hitPulse rising at cycle N gives hitPrev, lives, state and lifeLostPulse updated at edge N+1.

Test Plan:
- Reset, then a hitPulse high for 5 cycles from cycle 10 -> at cycle 11 lives 3->2, lifeLostPulse high for one cycle only, invulnerable=1, playerVisible=0.
- INVULN_FRAMES=4, BLINK_PERIOD=2, then hit and 4 startOfFrame pulses -> playerVisible 0,0,1,1 across the frames; returns to ALIVE on the 4th startOfFrame. A hit during the window leaves lives=2.
- hitPulse held high through the INVULN->ALIVE transition -> no decrement; a new rising edge afterwards decrements to 1.
- Three separated hits with invulnerability expiring between them -> lives 3,2,1,0; gameOver=1 after the third; playerVisible=1; further hits change nothing.
- In GAME_OVER, restart asserted together with a hitPulse rising edge -> lives=3, ALIVE, gameOver=0, no lifeLostPulse.
- reset asserted mid-INVULN, asynchronously between clock edges -> outputs immediately lives=3, invulnerable=0, playerVisible=1.

Source files
------------

// File: rtl/player_hit_manager.sv
// Player hit manager: tracks remaining lives, grants a frame-counted
// invulnerability window with a blink after each non-fatal hit, and
// flags game over. All outputs are registered.
module player_hit_manager #(
  parameter int INIT_LIVES    = 3,
  parameter int LIVES_W       = 3,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_PERIOD  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               hitPulse,
  input  logic               restart,
  output logic [LIVES_W-1:0] lives,
  output logic               invulnerable,
  output logic               playerVisible,
  output logic               gameOver,
  output logic               lifeLostPulse
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam int BLK_W = $clog2(BLINK_PERIOD + 1);

  localparam logic [1:0] ST_ALIVE     = 2'd0;
  localparam logic [1:0] ST_INVULN    = 2'd1;
  localparam logic [1:0] ST_GAME_OVER = 2'd2;

  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INVULN_FRAMES);
  localparam logic [INV_W-1:0]   INV_ONE    = INV_W'(1);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLINK_PERIOD - 1);
  localparam logic [BLK_W-1:0]   BLK_ONE    = BLK_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);

  logic [1:0]         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic               hit_prev_q;
  logic               life_lost_q, life_lost_d;
  logic               invulnerable_q, invulnerable_d;
  logic               visible_q, visible_d;
  logic               game_over_q, game_over_d;
  logic               hit_edge_s;

  // Rising edge of the hit level; a level held across state changes never retriggers.
  assign hit_edge_s = hitPulse & ~hit_prev_q;

  // Next-state logic: restart wins over everything, then per-state behaviour.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    inv_cnt_d     = inv_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    life_lost_d   = 1'b0;
    if (restart) begin
      state_d       = ST_ALIVE;
      lives_d       = LIVES_INIT;
      inv_cnt_d     = '0;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (hit_edge_s) begin
            life_lost_d = 1'b1;
            if (lives_q <= LIVES_ONE) begin
              lives_d = '0;
              state_d = ST_GAME_OVER;
            end else begin
              // Loading the window takes priority over a coincident frame start.
              lives_d       = lives_q - LIVES_ONE;
              state_d       = ST_INVULN;
              inv_cnt_d     = INV_LOAD;
              blink_cnt_d   = '0;
              blink_phase_d = 1'b0;
            end
          end else begin
            state_d = ST_ALIVE;
          end
        end
        ST_INVULN: begin
          if (startOfFrame) begin
            inv_cnt_d = inv_cnt_q - INV_ONE;
            if (blink_cnt_q == BLK_LAST) begin
              blink_cnt_d   = '0;
              blink_phase_d = ~blink_phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + BLK_ONE;
            end
            if (inv_cnt_q <= INV_ONE) begin
              state_d       = ST_ALIVE;
              inv_cnt_d     = '0;
              blink_cnt_d   = '0;
              blink_phase_d = 1'b0;
            end else begin
              state_d = ST_INVULN;
            end
          end else begin
            state_d = ST_INVULN;
          end
        end
        ST_GAME_OVER: begin
          lives_d = '0;
        end
        default: begin
          state_d = ST_ALIVE;
        end
      endcase
    end
  end

  // Output decode from the next state so every output comes straight from a flop.
  always_comb begin
    invulnerable_d = (state_d == ST_INVULN);
    game_over_d    = (state_d == ST_GAME_OVER);
    visible_d      = (state_d == ST_INVULN) ? blink_phase_d : 1'b1;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_ALIVE;
      lives_q        <= LIVES_INIT;
      inv_cnt_q      <= '0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      hit_prev_q     <= 1'b0;
      life_lost_q    <= 1'b0;
      invulnerable_q <= 1'b0;
      visible_q      <= 1'b1;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      inv_cnt_q      <= inv_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      hit_prev_q     <= hitPulse;
      life_lost_q    <= life_lost_d;
      invulnerable_q <= invulnerable_d;
      visible_q      <= visible_d;
      game_over_q    <= game_over_d;
    end
  end

  assign lives         = lives_q;
  assign invulnerable  = invulnerable_q;
  assign playerVisible = visible_q;
  assign gameOver      = game_over_q;
  assign lifeLostPulse = life_lost_q;

endmodule

// File: tb/tb_player_hit_manager.sv
// Self-checking bench for player_hit_manager: a vector table, hand-written
// corner sequences, and randomized traffic against a frame-level model.
module tb_player_hit_manager;

  localparam int INIT_LIVES = 3;
  localparam int LIVES_W    = 3;
  localparam int IF_N       = 4;
  localparam int BP_N       = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               hitPulse = 1'b0;
  logic               restart = 1'b0;
  logic [LIVES_W-1:0] lives;
  logic               invulnerable;
  logic               playerVisible;
  logic               gameOver;
  logic               lifeLostPulse;

  int passed = 0;
  int total  = 0;

  player_hit_manager #(
    .INIT_LIVES(INIT_LIVES), .LIVES_W(LIVES_W),
    .INVULN_FRAMES(IF_N), .BLINK_PERIOD(BP_N)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hitPulse(hitPulse),
    .restart(restart), .lives(lives), .invulnerable(invulnerable),
    .playerVisible(playerVisible), .gameOver(gameOver), .lifeLostPulse(lifeLostPulse)
  );

  always #5 clk = ~clk;

  // Frame-level model: lives, remaining protected frames, frames spent protected.
  int m_lives, m_left, m_spent;
  bit m_over, m_prev, m_pulse;

  task automatic model_reset();
    m_lives = INIT_LIVES; m_left = 0; m_spent = 0;
    m_over = 0; m_prev = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit sof, input bit hit, input bit rs);
    bit rose;
    rose    = hit && !m_prev;
    m_prev  = hit;
    m_pulse = 0;
    if (rs) begin
      m_lives = INIT_LIVES; m_over = 0; m_left = 0; m_spent = 0;
    end else if (m_over) begin
      m_lives = 0;
    end else if (m_left > 0) begin
      if (sof) begin
        m_left  = m_left - 1;
        m_spent = m_spent + 1;
      end
    end else if (rose) begin
      m_pulse = 1;
      m_lives = m_lives - 1;
      if (m_lives == 0) m_over = 1;
      else begin
        m_left = IF_N; m_spent = 0;
      end
    end
  endtask

  function automatic int m_visible();
    if (m_left > 0) return ((m_spent / BP_N) % 2 == 1) ? 1 : 0;
    return 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".lives"}, int'(lives), m_lives);
    chk({tag, ".inv"},   int'(invulnerable), (m_left > 0) ? 1 : 0);
    chk({tag, ".vis"},   int'(playerVisible), m_visible());
    chk({tag, ".go"},    int'(gameOver), m_over ? 1 : 0);
    chk({tag, ".pulse"}, int'(lifeLostPulse), m_pulse ? 1 : 0);
  endtask

  task automatic chk_const(input string tag, input int l, input int inv,
                           input int vis, input int go, input int p);
    chk({tag, ".lives"}, int'(lives), l);
    chk({tag, ".inv"},   int'(invulnerable), inv);
    chk({tag, ".vis"},   int'(playerVisible), vis);
    chk({tag, ".go"},    int'(gameOver), go);
    chk({tag, ".pulse"}, int'(lifeLostPulse), p);
  endtask

  // Drive one cycle's inputs at the falling edge, sample just after the rising edge.
  task automatic cyc(input bit sof, input bit hit, input bit rs);
    @(negedge clk);
    startOfFrame = sof; hitPulse = hit; restart = rs;
    model_step(sof, hit, rs);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit sof; bit hit; bit rs;
    int lives; int inv; int vis; int go; int pulse;
  } vec_t;

  vec_t tbl[10];
  bit   r_hit, r_rose, r_sof, r_rs;

  initial begin
    // Hit with a coincident frame start, then the 4-frame blink window.
    tbl[0] = '{0, 0, 0, 3, 0, 1, 0, 0};
    tbl[1] = '{1, 1, 0, 2, 1, 0, 0, 1};
    tbl[2] = '{0, 1, 0, 2, 1, 0, 0, 0};
    tbl[3] = '{1, 0, 0, 2, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 0, 2, 1, 0, 0, 0};
    tbl[5] = '{1, 0, 0, 2, 1, 1, 0, 0};
    tbl[6] = '{1, 0, 0, 2, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 0, 2, 1, 1, 0, 0};
    tbl[8] = '{1, 0, 0, 2, 0, 1, 0, 0};
    tbl[9] = '{0, 0, 0, 2, 0, 1, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_const("reset", 3, 0, 1, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].sof, tbl[i].hit, tbl[i].rs);
      chk_const($sformatf("tbl%0d", i), tbl[i].lives, tbl[i].inv, tbl[i].vis,
                tbl[i].go, tbl[i].pulse);
    end

    // Hit held high through the end of the window must not retrigger.
    cyc(0, 1, 0); chk_const("held.hit", 1, 1, 0, 0, 1);
    for (int i = 0; i < IF_N; i++) begin
      cyc(1, 1, 0); chk_all("held.win");
    end
    cyc(0, 1, 0); chk_const("held.exit", 1, 0, 1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0); chk_const("held.fatal", 0, 0, 1, 1, 1);
    cyc(0, 0, 0); chk_const("go.after", 0, 0, 1, 1, 0);
    cyc(0, 1, 0); chk_const("go.hit", 0, 0, 1, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 1); chk_const("go.restart", 3, 0, 1, 0, 0);
    cyc(0, 1, 0); chk_const("restart.noedge", 3, 0, 1, 0, 0);
    cyc(0, 0, 0);

    // Three separated hits, each window fully expiring.
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0);
      chk_const($sformatf("hit%0d", k), 2 - k, (k < 2) ? 1 : 0, (k < 2) ? 0 : 1,
                (k == 2) ? 1 : 0, 1);
      cyc(0, 0, 0);
      for (int f = 0; f < IF_N; f++) cyc(1, 0, 0);
      chk_all($sformatf("hit%0d.end", k));
    end
    chk_const("over", 0, 0, 1, 1, 0);
    cyc(0, 1, 0); chk_const("over.hit", 0, 0, 1, 1, 0);
    cyc(0, 0, 1); chk_all("over.restart");

    // Asynchronous reset between clock edges in the middle of a window.
    cyc(0, 1, 0); chk_const("ar.hit", 2, 1, 0, 0, 1);
    cyc(1, 0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_const("ar.async", 3, 0, 1, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 0); chk_all("ar.after");

    // Randomized traffic against the model.
    r_hit = 0; r_rose = 0;
    for (int n = 0; n < 600; n++) begin
      r_sof = ($urandom_range(0, 3) == 0);
      r_rs  = ($urandom_range(0, 59) == 0);
      if (r_sof) begin
        r_hit = 0; r_rose = 0;
      end else if (!r_hit && !r_rose && $urandom_range(0, 2) == 0) begin
        r_hit = 1; r_rose = 1;
      end
      cyc(r_sof, r_hit, r_rs);
      chk_all("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
